dma_line_engine: RTL
====================

// Module: dma_line_engine
// PURPOSE
// Descriptor-driven DMA engine. It moves N cache lines between the host line FIFOs and word-wide
// memory_controller DMA port, in either direction. Successor to the single-line dma_fsm: adds
// parametrised line/word/address widths, multi-line bursts, direction select, auto-increment
// addressing, abort and completion status. Sits between the AFU host FIFOs and memory_controller.
// PARAMETERS
// CL_SIZE_WIDTH  512  cache-line width in bits; must be a multiple of WORD_SIZE
// WORD_SIZE      32   memory word width in bits
// ADDR_WIDTH     28   memory word-address width
// CNT_WIDTH      16   width of the line-count field
// PORTS
// clk         in   1              clock; all logic on posedge
// rst         in   1              asynchronous, active-high reset
// start       in   1              1-cycle pulse; latches dir/base_addr/num_lines; ignored while busy
// dir         in   1              0 = host->mem (line to words), 1 = mem->host (words to line)
// base_addr   in   ADDR_WIDTH     word address of word 0 of line 0
// num_lines   in   CNT_WIDTH      number of lines to move; 0 is legal
// abort       in   1              terminate the current transfer
// busy        out  1              high from the cycle after start until DONE/IDLE
// done        out  1              1-cycle pulse at completion
// aborted     out  1              1-cycle pulse, together with done, when the transfer ended by abort
// empty       in   1              host read FIFO empty; dma_rd_data is show-ahead
// dma_rd_data in   CL_SIZE_WIDTH  head line of the host read FIFO
// rd_pop      out  1              pops the read FIFO
// wr_ready    in   1              host write FIFO can accept a line
// line_buffer out  CL_SIZE_WIDTH  assembled line toward the host
// wr_push     out  1              pushes line_buffer into the host write FIFO
// DMAEn       out  1              memory request strobe
// DMAWrEn     out  1              1 = write, 0 = read; valid only with DMAEn
// DMAAddr     out  ADDR_WIDTH     memory word address
// DMAData     out  WORD_SIZE      memory write data
// DMAOut      in   WORD_SIZE      memory read data
// DMAValid    in   1              DMAOut valid; variable latency; at most one read outstanding
// BEHAVIOUR
// - WPL = CL_SIZE_WIDTH/WORD_SIZE words per line. Word k of a line = line[WORD_SIZE*k +: WORD_SIZE].
//   Line j, word k maps to address base_addr + j*WPL + k, modulo 2**ADDR_WIDTH (wraps silently).
// - Reset: state IDLE, all outputs 0 (line_buffer included); the line and word counters clear.
// - States: IDLE, LOAD, WRITE, RD_REQ, RD_WAIT, PUSH, DONE.
// - IDLE: on start, latch the descriptor. num_lines==0 -> DONE. dir=0 -> LOAD. dir=1 -> RD_REQ.
// - LOAD: rd_pop = !empty (combinational); the line is latched on the pop edge, then -> WRITE.
//   Stalls indefinitely while empty.
// - WRITE: WPL consecutive cycles with DMAEn=DMAWrEn=1, DMAAddr/DMAData registered.
//   The first write occurs the cycle after the pop. After word WPL-1: next line -> LOAD, last -> DONE.
// - RD_REQ: one cycle with DMAEn=1 and DMAWrEn=0, then -> RD_WAIT.
// - RD_WAIT: on DMAValid, write DMAOut into word k of line_buffer. Then k<WPL-1 -> RD_REQ (k+1);
//   otherwise -> PUSH. DMAValid is ignored in every other state.
// - PUSH: wr_push = wr_ready (combinational); on push, next line -> RD_REQ, last -> DONE.
//   line_buffer holds stable until pushed.
// - DONE: done=1 for one cycle, busy=0, -> IDLE. A start arriving in DONE is ignored.
// - abort (any non-IDLE state) -> DONE with aborted=1. Effects of abort:
//   - A read already issued is dropped: a late DMAValid is ignored.
//   - No partial line is pushed.
//   - rd_pop is suppressed in the abort cycle.
// - abort in IDLE is ignored. abort has priority over pop/push/DMAValid in the same cycle.
// - Reset mid-transfer: immediate return to IDLE, no done pulse.
// - Counters are CNT_WIDTH bits (lines) and $clog2(WPL) bits (words), with no overflow.
// STRUCTURE
// - dma_pkg holds:
//   - typedef enum logic [2:0] dma_state_t;
//   - localparam function words_per_line(cl, w);
//   - typedef struct dma_desc_t {dir, base_addr, num_lines}.
// - Sub-module dma_line_buf (CL_SIZE_WIDTH, WORD_SIZE): a line register with parallel load,
//   word-select read (k) and word-insert write (k).
// - Top level holds the FSM, address/line/word counters, and output registers.
// TESTING
// 1 Host->mem, num_lines=1, base 0x100, line word k = k:
//   16 writes to 0x100..0x10F with data 0..15, one per cycle; done 1 cycle after the last write.
// 2 Mem->host, num_lines=2, base 0, memory[a]=a, DMAValid latency 1..4 random:
//   2 pushes with word k = k and 16+k; exactly 32 reads with none outstanding concurrently.
// 3 Host->mem, 3 lines, empty toggled 1 mid-burst and wr_ready held 0 in mem->host:
//   stalls, no extra DMAEn, correct addresses 0..47.
// 4 num_lines=0 -> done at cycle 2 after start with no DMAEn; base 0xFFFFFF8 with 1 line:
//   addresses wrap 0xFFFFFF8..0xFFFFFFF, 0x0..0x7.
// 5 abort during RD_WAIT: done+aborted same cycle, late DMAValid ignored, no wr_push;
//   a second start 2 cycles later runs normally.
// 6 rst asserted mid-WRITE (asynchronous, between edges): all outputs 0 immediately, IDLE, no done.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and helpers for the descriptor-driven DMA line engine.
package dma_pkg;

    localparam int DMA_ADDR_W = 28;
    localparam int DMA_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_PUSH    = 3'd5,
        ST_DONE    = 3'd6
    } dma_state_t;

    typedef struct packed {
        logic                  dir;
        logic [DMA_ADDR_W-1:0] base_addr;
        logic [DMA_CNT_W-1:0]  num_lines;
    } dma_desc_t;

    function automatic int words_per_line(input int cl, input int w);
        return cl / w;
    endfunction

    // A one-word line still needs a 1-bit index to keep the ports legal.
    function automatic int word_idx_width(input int wpl);
        return (wpl > 1) ? $clog2(wpl) : 1;
    endfunction

endpackage

// File: rtl/dma_line_buf.sv
// Cache-line register: whole-line load from the host FIFO, single-word insert
// from memory reads, and a word-select read port feeding memory writes.
module dma_line_buf
    import dma_pkg::*;
#(
    parameter int CL_SIZE_WIDTH = 512,
    parameter int WORD_SIZE     = 32,
    localparam int WPL          = words_per_line(CL_SIZE_WIDTH, WORD_SIZE),
    localparam int KW           = word_idx_width(WPL)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [CL_SIZE_WIDTH-1:0] load_line,
    input  logic                     ins_en,
    input  logic [KW-1:0]            ins_k,
    input  logic [WORD_SIZE-1:0]     ins_word,
    input  logic [KW-1:0]            rd_k,
    output logic [WORD_SIZE-1:0]     rd_word,
    output logic [CL_SIZE_WIDTH-1:0] line
);

    logic [WPL-1:0][WORD_SIZE-1:0] words_q, words_d;

    always_comb begin
        words_d = words_q;
        if (load_en) begin
            words_d = load_line;
        end else if (ins_en) begin
            words_d[ins_k] = ins_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign rd_word = words_q[rd_k];
    assign line    = words_q;

endmodule

// File: rtl/dma_line_engine.sv
// Multi-line DMA engine moving cache lines between host FIFOs and a word-wide
// memory port; addresses auto-increment one word per transfer from base_addr.
module dma_line_engine
    import dma_pkg::*;
#(
    parameter int CL_SIZE_WIDTH = 512,
    parameter int WORD_SIZE     = 32,
    parameter int ADDR_WIDTH    = DMA_ADDR_W,
    parameter int CNT_WIDTH     = DMA_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     dir,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [CNT_WIDTH-1:0]     num_lines,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    input  logic                     empty,
    input  logic [CL_SIZE_WIDTH-1:0] dma_rd_data,
    output logic                     rd_pop,
    input  logic                     wr_ready,
    output logic [CL_SIZE_WIDTH-1:0] line_buffer,
    output logic                     wr_push,
    output logic                     DMAEn,
    output logic                     DMAWrEn,
    output logic [ADDR_WIDTH-1:0]    DMAAddr,
    output logic [WORD_SIZE-1:0]     DMAData,
    input  logic [WORD_SIZE-1:0]     DMAOut,
    input  logic                     DMAValid
);

    localparam int WPL              = words_per_line(CL_SIZE_WIDTH, WORD_SIZE);
    localparam int KW               = word_idx_width(WPL);
    localparam logic [KW-1:0] LAST_K = KW'(WPL - 1);

    dma_state_t              state_q, state_d;
    logic [CNT_WIDTH-1:0]    lines_q, lines_d;
    logic [KW-1:0]           word_q, word_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]    data_q, data_d;
    logic                    aborted_q, aborted_d;

    dma_desc_t               desc_in;
    logic                    active;
    logic                    abort_hit;
    logic                    last_line;
    logic                    buf_load, buf_ins;
    logic [KW-1:0]           word_nxt;
    logic [WORD_SIZE-1:0]    buf_word;

    assign desc_in = '{dir:       dir,
                       base_addr: DMA_ADDR_W'(base_addr),
                       num_lines: DMA_CNT_W'(num_lines)};

    assign active    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign abort_hit = abort && active;
    assign last_line = (lines_q == CNT_WIDTH'(1));
    assign word_nxt  = word_q + KW'(1);

    dma_line_buf #(
        .CL_SIZE_WIDTH (CL_SIZE_WIDTH),
        .WORD_SIZE     (WORD_SIZE)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .load_en   (buf_load),
        .load_line (dma_rd_data),
        .ins_en    (buf_ins),
        .ins_k     (word_q),
        .ins_word  (DMAOut),
        .rd_k      (word_nxt),
        .rd_word   (buf_word),
        .line      (line_buffer)
    );

    always_comb begin
        state_d   = state_q;
        lines_d   = lines_q;
        word_d    = word_q;
        addr_d    = addr_q;
        data_d    = data_q;
        aborted_d = aborted_q;
        buf_load  = 1'b0;
        buf_ins   = 1'b0;
        if (abort_hit) begin
            // Abort wins over pop/push/DMAValid; any outstanding read is simply forgotten.
            state_d   = ST_DONE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_d    = ADDR_WIDTH'(desc_in.base_addr);
                        lines_d   = CNT_WIDTH'(desc_in.num_lines);
                        word_d    = '0;
                        aborted_d = 1'b0;
                        if (desc_in.num_lines == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = desc_in.dir ? ST_RD_REQ : ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (!empty) begin
                        buf_load = 1'b1;
                        data_d   = dma_rd_data[WORD_SIZE-1:0];
                        word_d   = '0;
                        state_d  = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (word_q == LAST_K) begin
                        word_d  = '0;
                        lines_d = lines_q - CNT_WIDTH'(1);
                        state_d = last_line ? ST_DONE : ST_LOAD;
                    end else begin
                        word_d = word_nxt;
                        data_d = buf_word;
                    end
                end
                ST_RD_REQ: begin
                    state_d = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (DMAValid) begin
                        buf_ins = 1'b1;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        if (word_q == LAST_K) begin
                            word_d  = '0;
                            state_d = ST_PUSH;
                        end else begin
                            word_d  = word_nxt;
                            state_d = ST_RD_REQ;
                        end
                    end
                end
                ST_PUSH: begin
                    if (wr_ready) begin
                        lines_d = lines_q - CNT_WIDTH'(1);
                        state_d = last_line ? ST_DONE : ST_RD_REQ;
                    end
                end
                ST_DONE: begin
                    aborted_d = 1'b0;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lines_q   <= '0;
            word_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lines_q   <= lines_d;
            word_q    <= word_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            aborted_q <= aborted_d;
        end
    end

    assign busy    = active;
    assign done    = (state_q == ST_DONE);
    assign aborted = (state_q == ST_DONE) && aborted_q;
    assign rd_pop  = (state_q == ST_LOAD) && !empty && !abort;
    assign wr_push = (state_q == ST_PUSH) && wr_ready && !abort;
    assign DMAEn   = (state_q == ST_WRITE) || (state_q == ST_RD_REQ);
    assign DMAWrEn = (state_q == ST_WRITE);
    assign DMAAddr = addr_q;
    assign DMAData = data_q;

endmodule
